// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for the multicycle ARM datapath. It decodes the instruction
// fields held in the instruction register, steps through the per-instruction
// state sequence and drives every datapath select and write enable. It also
// owns the NZCV flag register and the condition-execute gating that
// suppresses architectural writes of instructions whose condition fails.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   Cond        Instr[31:28] condition field
//   Op          Instr[27:26] opcode class
//   Funct       Instr[25:20] {I, cmd[3:0], S/L}
//   Rd          Instr[15:12] destination register
//   ALUFlags    NZCV produced by the ALU in the current cycle
//   PCWrite     PC write enable
//   MemWrite    data memory write enable
//   RegWrite    register file write enable
//   IRWrite     instruction register write enable
//   AdrSrc      memory address select (0 = PC, 1 = ALUOut)
//   ALUSrcA     ALU A select (0 = register A, 1 = PC)
//   ALUSrcB     ALU B select (00 = register B, 01 = ExtImm, 10 = 4)
//   ResultSrc   result select (00 = ALUOut, 01 = read data, 10 = ALUResult)
//   ImmSrc      immediate format for ExtendImmediate
//   RegSrc      register-file read-address steering for branch/store
//   ALUControl  ALU operation (00 add, 01 sub, 10 and, 11 orr)
//   Flags       registered NZCV
//   State       current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } stateT;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Evaluates an ARM condition code against NZCV = flags[3:0].
    function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic result;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: result = z;
            4'b0001: result = ~z;
            4'b0010: result = c;
            4'b0011: result = ~c;
            4'b0100: result = n;
            4'b0101: result = ~n;
            4'b0110: result = v;
            4'b0111: result = ~v;
            4'b1000: result = c & ~z;
            4'b1001: result = ~c | z;
            4'b1010: result = (n == v);
            4'b1011: result = (n != v);
            4'b1100: result = ~z & (n == v);
            4'b1101: result = z | (n != v);
            4'b1110: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    stateT      state;
    stateT      nextState;
    logic       cond_ex_q;
    logic       condEx;
    logic       irWrite;
    logic       nextPC;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       aluOp;
    logic       setFlags;
    logic       arithCmd;
    logic       isCmp;
    logic [3:0] cmd;

    assign cmd    = Funct[4:1];
    assign isCmp  = (cmd == CMD_CMP);
    assign condEx = condCheck(Cond, Flags);

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Condition result sampled once in DECODE and held for the rest of the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_q <= 1'b0;
        end else if (state == DECODE) begin
            cond_ex_q <= condEx;
        end else begin
            cond_ex_q <= cond_ex_q;
        end
    end

    // NZCV register: NZ on any flag-setting op, CV only for arithmetic ops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (aluOp && setFlags && cond_ex_q) begin
            Flags[3:2] <= ALUFlags[3:2];
            if (arithCmd) begin
                Flags[1:0] <= ALUFlags[1:0];
            end else begin
                Flags[1:0] <= Flags[1:0];
            end
        end else begin
            Flags <= Flags;
        end
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        nextState = FETCH;
        irWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        nextPC    = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        branch    = 1'b0;
        aluOp     = 1'b0;
        case (state)
            FETCH: begin
                irWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                nextPC    = 1'b1;
                nextState = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00: begin
                        if (Funct[5]) begin
                            nextState = EXECUTEI;
                        end else begin
                            nextState = EXECUTER;
                        end
                    end
                    2'b01:   nextState = MEMADR;
                    2'b10:   nextState = BRANCH;
                    default: nextState = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                if (Funct[0]) begin
                    nextState = MEMREAD;
                end else begin
                    nextState = MEMWRITE;
                end
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                nextState = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regW      = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                memW      = 1'b1;
                nextState = FETCH;
            end
            EXECUTER: begin
                aluOp     = 1'b1;
                nextState = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB   = 2'b01;
                aluOp     = 1'b1;
                nextState = ALUWB;
            end
            ALUWB: begin
                regW      = ~isCmp;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                nextState = FETCH;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    // ALU operation decode; CMP is a subtract that always sets flags.
    always_comb begin
        ALUControl = 2'b00;
        setFlags   = 1'b0;
        arithCmd   = 1'b0;
        if (aluOp) begin
            case (cmd)
                CMD_ADD: ALUControl = 2'b00;
                CMD_SUB: ALUControl = 2'b01;
                CMD_AND: ALUControl = 2'b10;
                CMD_ORR: ALUControl = 2'b11;
                CMD_CMP: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
            setFlags = Funct[0] | isCmp;
            arithCmd = (cmd == CMD_ADD) | (cmd == CMD_SUB) | isCmp;
        end else begin
            ALUControl = 2'b00;
            setFlags   = 1'b0;
            arithCmd   = 1'b0;
        end
    end

    // Write enables: condition gating plus an explicit reset override so the
    // FETCH enables stay low while reset is held.
    always_comb begin
        IRWrite  = irWrite & reset;
        RegWrite = regW & cond_ex_q & reset;
        MemWrite = memW & cond_ex_q & reset;
        PCWrite  = reset & (nextPC | (branch & cond_ex_q)
                            | (regW & (Rd == 4'd15) & cond_ex_q));
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
    assign State  = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] Flags;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        Cond     = 4'b1110;
        Op       = 2'b00;
        Funct    = 6'b000000;
        Rd       = 4'd0;
        ALUFlags = 4'b0000;

        // Reset held: FETCH state, clear flags, enables low, FETCH selects
        tick();
        tick();
        chk("rst_state", State, 4'd0);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_irw", {3'b000, IRWrite}, 4'd0);
        chk("rst_pcw", {3'b000, PCWrite}, 4'd0);
        chk("rst_regw", {3'b000, RegWrite}, 4'd0);
        chk("rst_memw", {3'b000, MemWrite}, 4'd0);
        chk("rst_srcb", {2'b00, ALUSrcB}, 4'd2);
        chk("rst_res", {2'b00, ResultSrc}, 4'd2);

        // Release: FETCH enables come up
        reset = 1'b1;
        #1;
        chk("rel_irw", {3'b000, IRWrite}, 4'd1);
        chk("rel_pcw", {3'b000, PCWrite}, 4'd1);

        // Start an LDR, then reset in the middle of MEMADR
        Op    = 2'b01;
        Funct = 6'b011001;
        tick();
        chk("mid_decode", State, 4'd1);
        tick();
        chk("mid_memadr", State, 4'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_state", State, 4'd0);
        chk("mid_rst_en", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
        chk("mid_rst_flags", Flags, 4'b0000);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_irw", {3'b000, IRWrite}, 4'd1);

        // ADDS R1,R2,#200 with ALU NZCV=0100
        Cond     = 4'b1110;
        Op       = 2'b00;
        Funct    = 6'b101001;
        Rd       = 4'd1;
        ALUFlags = 4'b0100;
        chk("adds_fetch", State, 4'd0);
        tick();
        chk("adds_decode", State, 4'd1);
        chk("adds_imm", {2'b00, ImmSrc}, 4'd0);
        tick();
        chk("adds_exi", State, 4'd7);
        chk("adds_aluc", {2'b00, ALUControl}, 4'd0);
        chk("adds_srcb", {2'b00, ALUSrcB}, 4'd1);
        tick();
        chk("adds_aluwb", State, 4'd8);
        chk("adds_regw", {3'b000, RegWrite}, 4'd1);
        chk("adds_pcw", {3'b000, PCWrite}, 4'd0);
        chk("adds_flags", Flags, 4'b0100);
        tick();
        chk("adds_done", State, 4'd0);

        // LDR: five cycles, RegWrite only in MEMWB
        Op       = 2'b01;
        Funct    = 6'b011001;
        Rd       = 4'd3;
        ALUFlags = 4'b0000;
        tick();
        chk("ldr_imm", {2'b00, ImmSrc}, 4'd1);
        chk("ldr_regsrc", {2'b00, RegSrc}, 4'd0);
        tick();
        chk("ldr_memadr", State, 4'd2);
        chk("ldr_regw2", {3'b000, RegWrite}, 4'd0);
        tick();
        chk("ldr_memread", State, 4'd3);
        chk("ldr_adrsrc", {3'b000, AdrSrc}, 4'd1);
        chk("ldr_regw3", {3'b000, RegWrite}, 4'd0);
        tick();
        chk("ldr_memwb", State, 4'd4);
        chk("ldr_regw4", {3'b000, RegWrite}, 4'd1);
        chk("ldr_res", {2'b00, ResultSrc}, 4'd1);
        tick();
        chk("ldr_done", State, 4'd0);
        chk("ldr_flags", Flags, 4'b0100);

        // STRNE with Z=1: write suppressed
        Cond  = 4'b0001;
        Funct = 6'b011000;
        tick();
        chk("strne_regsrc", {2'b00, RegSrc}, 4'd2);
        tick();
        tick();
        chk("strne_memwr", State, 4'd5);
        chk("strne_memw", {3'b000, MemWrite}, 4'd0);
        chk("strne_adrsrc", {3'b000, AdrSrc}, 4'd1);
        tick();
        chk("strne_done", State, 4'd0);

        // STR (always): write happens
        Cond = 4'b1110;
        tick();
        tick();
        tick();
        chk("str_memwr", State, 4'd5);
        chk("str_memw", {3'b000, MemWrite}, 4'd1);
        tick();

        // CMP R1,#5 with ALU NZCV=0110
        Op       = 2'b00;
        Funct    = 6'b110101;
        Rd       = 4'd0;
        ALUFlags = 4'b0110;
        tick();
        tick();
        chk("cmp_exi", State, 4'd7);
        chk("cmp_aluc", {2'b00, ALUControl}, 4'd1);
        tick();
        chk("cmp_regw", {3'b000, RegWrite}, 4'd0);
        chk("cmp_flags", Flags, 4'b0110);
        tick();

        // ANDS NE with Z=1: condition fails, flags untouched
        Cond     = 4'b0001;
        Funct    = 6'b000001;
        ALUFlags = 4'b1000;
        tick();
        tick();
        chk("andne_exr", State, 4'd6);
        chk("andne_aluc", {2'b00, ALUControl}, 4'd2);
        tick();
        chk("andne_regw", {3'b000, RegWrite}, 4'd0);
        chk("andne_flags", Flags, 4'b0110);
        tick();

        // BEQ taken (Z=1)
        Cond     = 4'b0000;
        Op       = 2'b10;
        Funct    = 6'b000000;
        ALUFlags = 4'b0000;
        tick();
        chk("beq_imm", {2'b00, ImmSrc}, 4'd2);
        chk("beq_regsrc", {2'b00, RegSrc}, 4'd1);
        tick();
        chk("beq_branch", State, 4'd9);
        chk("beq_pcw", {3'b000, PCWrite}, 4'd1);
        tick();
        chk("beq_done", State, 4'd0);

        // BNE not taken
        Cond = 4'b0001;
        tick();
        tick();
        chk("bne_branch", State, 4'd9);
        chk("bne_pcw", {3'b000, PCWrite}, 4'd0);
        tick();

        // ADD R15,R1,R2: register write plus PC write
        Cond  = 4'b1110;
        Op    = 2'b00;
        Funct = 6'b001000;
        Rd    = 4'd15;
        tick();
        tick();
        chk("addpc_exr", State, 4'd6);
        chk("addpc_srcb", {2'b00, ALUSrcB}, 4'd0);
        tick();
        chk("addpc_pcw", {3'b000, PCWrite}, 4'd1);
        chk("addpc_regw", {3'b000, RegWrite}, 4'd1);
        chk("addpc_flags", Flags, 4'b0110);
        tick();

        // Op=11: two cycles, no writes
        Op = 2'b11;
        Rd = 4'd0;
        tick();
        chk("op11_decode", State, 4'd1);
        chk("op11_en", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
        tick();
        chk("op11_done", State, 4'd0);

        // Reset clears populated flags
        reset = 1'b0;
        #1;
        chk("rst2_flags", Flags, 4'b0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Sequences the multicycle ARM datapath: register file, ALU, instruction/data memory and `ExtendImmediate`.
- Decodes the latched instruction fields and walks a per-instruction state machine.
- Drives all mux selects and write enables, including `ImmSrc`.
- Keeps the NZCV flag register and the condition-execute gating that suppresses architectural writes.

## Interface
- No parameters; all widths are fixed by the ARM instruction format.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `Cond`  in  4  Instr[31:28]
- `Op`  in  2  Instr[27:26]
- `Funct`  in  6  Instr[25:20] (I, cmd[3:0], S/L)
- `Rd`  in  4  Instr[15:12]
- `ALUFlags`  in  4  NZCV from ALU (current cycle)
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`  out  1 each  write enables
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ALUSrcA`  out  1  0 = register A, 1 = PC
- `ALUSrcB`  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- `ResultSrc`  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
- `ImmSrc`  out  2  00 = imm8 zero-ext, 01 = imm12 zero-ext, 10 = imm24 sign-ext <<2
- `RegSrc`  out  2  [0] = 1 reads R15 for Rn (branch), [1] = 1 reads Rd for Rm (store)
- `ALUControl`  out  2  00 = add, 01 = sub, 10 = and, 11 = orr
- `Flags`  out  4  registered NZCV
- `State`  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Encodings 10–15 are illegal and go to FETCH next cycle with all enables 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10, NextPC=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10; latch CondEx into `cond_ex_q`. Next state by opcode:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECUTER; with Funct[5]=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH, no writes
- MEMADR: ALUSrcA=0, ALUSrcB=01, add. Next MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next ALUWB.
- ALUWB: ResultSrc=00, RegW=1 unless CMP. Next FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, Branch=1. Next FETCH.
- ImmSrc = Op; RegSrc = {Op==01 & ~Funct[0], Op==10}. Both are decoded from the inputs, not from the state.
- ALU decode (ALUOp=1, cmd=Funct[4:1]):
  - ADD 0100 → 00
  - SUB 0010 → 01
  - AND 0000 → 10
  - ORR 1100 → 11
  - CMP 1010 → 01 with S forced to 1 and NoWrite
  - any other cmd → 00
  - ALUOp=0 always gives 00.
- CondEx by Cond:
  - EQ: Z
  - NE: ~Z
  - CS: C
  - CC: ~C
  - MI: N
  - PL: ~N
  - VS: V
  - VC: ~V
  - HI: C&~Z
  - LS: ~C|Z
  - GE: N==V
  - LT: N!=V
  - GT: ~Z&(N==V)
  - LE: Z|(N!=V)
  - AL (1110): 1
  - 1111: 0
- Write gating:
  - RegWrite = RegW & cond_ex_q
  - MemWrite = MemW & cond_ex_q
  - PCWrite = NextPC | (Branch & cond_ex_q) | (RegW & Rd==15 & cond_ex_q)
- Flags update: NZ when S; CV when S & cmd ∈ {ADD, SUB, CMP}. Captured from ALUFlags at the end of EXECUTER/EXECUTEI, and only if cond_ex_q=1.

## Timing
- Reset asserted (reset=0):
  - State=FETCH, Flags=0000, cond_ex_q=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - Selects show the FETCH values.
- Reset takes effect immediately, including mid-instruction; the partial instruction is abandoned with no write.
- The first FETCH enables assert in the cycle after reset rises.
- Outputs are combinational from State, inputs and cond_ex_q. State, Flags and cond_ex_q update on rising `clk`.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
- The flags written in EXECUTE* are not visible to the same instruction's gating, because gating uses cond_ex_q latched in DECODE.
- Cond/Op/Funct/Rd must be stable from DECODE through the last state (IR holds them).

## Test plan
- Reset low mid-MEMADR, then high → State=0, Flags=0, all four enables 0 during reset; IRWrite=1 one cycle after release.
- ADDS R1,R2,#200 (Cond=1110, Op=00, Funct=101001), ALUFlags=0100 → states 0,1,7,8; ImmSrc=00, ALUControl=00; RegWrite=1 in ALUWB; Flags=0100 after EXECUTEI.
- LDR (Op=01, Funct=011001) → states 0,1,2,3,4; ImmSrc=01; AdrSrc=1 in MEMREAD; RegWrite=1 only in MEMWB; 5 cycles.
- STRNE (Cond=0001, Funct=011000) with Flags Z=1 → states 0,1,2,5; RegSrc[1]=1; MemWrite stays 0.
- CMP R1,#5 (Funct=110101), ALUFlags=0110 → RegWrite=0 in ALUWB, ALUControl=01, Flags=0110. Then BEQ (Op=10) → PCWrite=1 in BRANCH, ImmSrc=10; BNE → PCWrite=0.
- ADD R15,R1,R2 (Rd=15) → PCWrite=1 and RegWrite=1 in ALUWB.
